axi_lite_slave_mem: RTL and testbench

//   AXI4-Lite slave with a byte-addressed local memory. Sits directly

---
 rtl/axi_lite_slave_mem.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave terminating all five channels onto a byte-lane local memory.
// The write and read paths run independently, with one outstanding transaction each.
module axi_lite_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_W-1:0]     ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int LANE_AW = $clog2(STRB_W);
    localparam int MEM_AW  = $clog2(MEM_BYTES);
    localparam int IDX_W   = MEM_AW - LANE_AW;
    localparam int WORDS   = MEM_BYTES / STRB_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Shared
    logic                 r_ready_en;

    // Write path
    wr_state_t            r_wr_state;
    wr_state_t            w_wr_state_next;
    logic                 r_aw_got;
    logic                 r_w_got;
    logic [ADDR_W-1:0]    r_awaddr;
    logic [DATA_W-1:0]    r_wdata;
    logic [STRB_W-1:0]    r_wstrb;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 w_awready;
    logic                 w_wready;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_commit;
    logic                 w_b_hs;
    logic                 w_aw_oor;
    logic [IDX_W-1:0]     w_wr_idx;

    // Read path
    rd_state_t            r_rd_state;
    rd_state_t            w_rd_state_next;
    logic                 r_rvalid;
    logic [1:0]           r_rresp;
    logic [DATA_W-1:0]    r_rdata;
    logic                 w_arready;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_ar_oor;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [DATA_W-1:0]    w_rd_word;

    assign w_wr_idx = r_awaddr[MEM_AW-1:LANE_AW];
    assign w_rd_idx = ARADDR[MEM_AW-1:LANE_AW];

    generate
        if (ADDR_W > MEM_AW) begin : g_range
            assign w_aw_oor = |r_awaddr[ADDR_W-1:MEM_AW];
            assign w_ar_oor = |ARADDR[ADDR_W-1:MEM_AW];
        end else begin : g_no_range
            assign w_aw_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end

        // Sub-word address bits select nothing: accesses are always whole-word aligned.
        if (LANE_AW > 0) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^{r_awaddr[LANE_AW-1:0], ARADDR[LANE_AW-1:0]};
        end
    endgenerate

    // Readies come up one edge after reset release, never during reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_state_next = r_wr_state;
        w_awready       = 1'b0;
        w_wready        = 1'b0;
        w_commit        = 1'b0;
        w_b_hs          = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = r_ready_en && !r_aw_got;
                w_wready  = r_ready_en && !r_w_got;
                if (r_aw_got && r_w_got) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    w_b_hs          = 1'b1;
                    w_wr_state_next = WR_IDLE;
                end
            end
            default: w_wr_state_next = WR_IDLE;
        endcase
    end

    assign w_aw_hs = AWVALID && w_awready;
    assign w_w_hs  = WVALID && w_wready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_state <= WR_IDLE;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_next;
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_awaddr <= AWADDR;
            end
            if (w_w_hs) begin
                r_w_got <= 1'b1;
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_b_hs) begin
                r_bvalid <= 1'b0;
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory: one 8-bit array per byte lane so each strobe is a plain write enable.
    // Reads sample the array with non-blocking semantics, so a read on the
    // commit edge of the same word returns the pre-write contents.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] r_mem [WORDS];

            always_ff @(posedge ACLK) begin
                if (w_commit && !w_aw_oor && r_wstrb[gi]) begin
                    r_mem[w_wr_idx] <= r_wdata[gi*8 +: 8];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_mem[w_rd_idx];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_state_next = r_rd_state;
        w_arready       = 1'b0;
        w_ar_hs         = 1'b0;
        w_r_hs          = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_arready = r_ready_en;
                if (ARVALID && r_ready_en) begin
                    w_ar_hs         = 1'b1;
                    w_rd_state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RREADY) begin
                    w_r_hs          = 1'b1;
                    w_rd_state_next = RD_IDLE;
                end
            end
            default: w_rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            r_rd_state <= w_rd_state_next;
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
                r_rdata  <= w_ar_oor ? '0 : w_rd_word;
            end
            if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign AWREADY = w_awready;
    assign WREADY  = w_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = w_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: a vector table of writes/reads with hand-derived
// expectations fed through response scoreboards, plus hand sequences for collisions and reset.
module tb_axi_lite_slave_mem;
    logic        ACLK;
    logic        ARESETn;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    axi_lite_slave_mem #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_BYTES (4096)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;      // cycles W is presented ahead of AW
        int          hold;      // cycles BREADY/RREADY held low once VALID
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    vec_t        vecs[$];
    logic [1:0]  b_q[$];
    rexp_t       r_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic vec_t mk(input bit r, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int lead, input int hold,
                                input logic [1:0] resp, input logic [31:0] exp);
        vec_t v;
        v.is_read  = r;
        v.addr     = a;
        v.data     = d;
        v.strb     = s;
        v.lead     = lead;
        v.hold     = hold;
        v.exp_resp = resp;
        v.exp_data = exp;
        return v;
    endfunction

    task automatic run_write(input vec_t v);
        int  guard;
        bit  aw_pend;
        bit  w_pend;
        bit  hs_aw;
        bit  hs_w;
        logic [1:0] exp;
        b_q.push_back(v.exp_resp);
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        WVALID  = 1'b1;
        WDATA   = v.data;
        WSTRB   = v.strb;
        for (int i = 0; i < v.lead; i++) begin
            hs_w = WVALID && WREADY;
            step();
            if (hs_w) begin
                WVALID = 1'b0;
                w_pend = 1'b0;
            end
            if (!w_pend) check("wready_low_after_w", WREADY, 0);
        end
        AWVALID = 1'b1;
        AWADDR  = v.addr;
        guard   = 0;
        while ((aw_pend || w_pend) && guard < 16) begin
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            step();
            guard++;
            if (hs_aw) begin
                AWVALID = 1'b0;
                aw_pend = 1'b0;
            end
            if (hs_w) begin
                WVALID = 1'b0;
                w_pend = 1'b0;
            end
        end
        check("aw_w_accept_timeout", {aw_pend, w_pend}, 0);
        check("bvalid_before_commit", BVALID, 0);
        step();
        check("bvalid_latency", BVALID, 1);
        check("aw_w_ready_busy", {AWREADY, WREADY}, 0);
        for (int i = 0; i < v.hold; i++) begin
            step();
            check("bvalid_hold", BVALID, 1);
            check("bresp_hold", BRESP, v.exp_resp);
            check("aw_w_ready_hold", {AWREADY, WREADY}, 0);
        end
        BREADY = 1'b1;
        if (b_q.size() == 0) begin
            check("b_scoreboard_empty", 1, 0);
        end else begin
            exp = b_q.pop_front();
            check("bresp", BRESP, exp);
        end
        step();
        BREADY = 1'b0;
        check("bvalid_clear", BVALID, 0);
        check("aw_w_ready_back", {AWREADY, WREADY}, 2'b11);
        $display("WR addr=0x%08h data=0x%08h strb=%b bresp=%b", v.addr, v.data, v.strb, BRESP);
    endtask

    task automatic run_read(input vec_t v);
        int    guard;
        bit    hs;
        rexp_t exp;
        r_q.push_back('{data: v.exp_data, resp: v.exp_resp});
        ARVALID = 1'b1;
        ARADDR  = v.addr;
        guard   = 0;
        hs      = 1'b0;
        while (!hs && guard < 16) begin
            hs = ARVALID && ARREADY;
            step();
            guard++;
        end
        ARVALID = 1'b0;
        check("ar_accept_timeout", hs, 1);
        check("rvalid_zero_wait", RVALID, 1);
        check("arready_busy", ARREADY, 0);
        for (int i = 0; i < v.hold; i++) begin
            step();
            check("rvalid_hold", RVALID, 1);
            check("rdata_hold", RDATA, v.exp_data);
            check("arready_hold", ARREADY, 0);
        end
        RREADY = 1'b1;
        if (r_q.size() == 0) begin
            check("r_scoreboard_empty", 1, 0);
        end else begin
            exp = r_q.pop_front();
            check("rdata", RDATA, exp.data);
            check("rresp", RRESP, exp.resp);
        end
        $display("RD addr=0x%08h rdata=0x%08h rresp=%b", v.addr, RDATA, RRESP);
        step();
        RREADY = 1'b0;
        check("rvalid_clear", RVALID, 0);
        check("arready_back", ARREADY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        AWVALID = 1'b0;
        AWADDR  = '0;
        WVALID  = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        BREADY  = 1'b0;
        ARVALID = 1'b0;
        ARADDR  = '0;
        RREADY  = 1'b0;

        //            rd addr           data          strb    ld hd resp   exp_data
        vecs.push_back(mk(0, 32'h0000_0010, 32'hDEADBEEF, 4'hF,    0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0010, 32'h0,        4'h0,    0, 0, 2'b00, 32'hDEADBEEF));
        vecs.push_back(mk(0, 32'h0000_0010, 32'h11223344, 4'b0101, 3, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0010, 32'h0,        4'h0,    0, 0, 2'b00, 32'hDE22BE44));
        vecs.push_back(mk(0, 32'h0000_0000, 32'hCAFEF00D, 4'hF,    0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(0, 32'h0000_1000, 32'hFFFFFFFF, 4'hF,    0, 0, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0000, 32'h0,        4'h0,    0, 0, 2'b00, 32'hCAFEF00D));
        vecs.push_back(mk(1, 32'h0000_2000, 32'h0,        4'h0,    0, 0, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h0000_0014, 32'h01020304, 4'hF,    0, 5, 2'b00, 32'h0));
        vecs.push_back(mk(0, 32'h0000_0017, 32'hAA000000, 4'b1000, 0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0016, 32'h0,        4'h0,    0, 4, 2'b00, 32'hAA020304));
        vecs.push_back(mk(0, 32'h0000_0014, 32'hFFFFFFFF, 4'h0,    0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0014, 32'h0,        4'h0,    0, 0, 2'b00, 32'hAA020304));
        vecs.push_back(mk(0, 32'h0000_0FFC, 32'h5555AAAA, 4'hF,    1, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0FFF, 32'h0,        4'h0,    0, 0, 2'b00, 32'h5555AAAA));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'h0,        4'h0,    0, 0, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h0000_1010, 32'h0,        4'h0,    0, 0, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h0000_0020, 32'h12345678, 4'hF,    0, 0, 2'b00, 32'h0));

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst_valids", {BVALID, RVALID}, 2'b00);
        check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_rdata", RDATA, 0);
        ARESETn = 1'b1;
        check("release_readies_low", {AWREADY, WREADY, ARREADY}, 3'b000);
        step();
        check("release_readies_high", {AWREADY, WREADY, ARREADY}, 3'b111);

        foreach (vecs[i]) begin
            if (vecs[i].is_read) run_read(vecs[i]);
            else                 run_write(vecs[i]);
        end

        // Read and write commit to the same word on one edge: old data returned.
        AWVALID = 1'b1;
        AWADDR  = 32'h20;
        WVALID  = 1'b1;
        WDATA   = 32'h9ABCDEF0;
        WSTRB   = 4'hF;
        check("coll_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = 32'h20;
        check("coll_arready", ARREADY, 1);
        step();
        ARVALID = 1'b0;
        check("coll_bvalid", BVALID, 1);
        check("coll_rvalid", RVALID, 1);
        check("coll_old_data", RDATA, 32'h12345678);
        check("coll_rresp", RRESP, 0);
        BREADY = 1'b1;
        RREADY = 1'b1;
        step();
        BREADY = 1'b0;
        RREADY = 1'b0;
        check("coll_both_done", {BVALID, RVALID}, 2'b00);
        $display("COLL addr=0x00000020 old=0x12345678 new=0x9ABCDEF0");
        run_read(mk(1, 32'h20, 32'h0, 4'h0, 0, 0, 2'b00, 32'h9ABCDEF0));

        // Reset while both BVALID and RVALID are pending.
        AWVALID = 1'b1;
        AWADDR  = 32'h30;
        WVALID  = 1'b1;
        WDATA   = 32'h0BADC0DE;
        WSTRB   = 4'hF;
        ARVALID = 1'b1;
        ARADDR  = 32'h20;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        step();
        check("prerst_valids", {BVALID, RVALID}, 2'b11);
        #2;
        ARESETn = 1'b0;
        #1;
        check("midrst_valids", {BVALID, RVALID}, 2'b00);
        check("midrst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("midrst_rdata", RDATA, 0);
        check("midrst_bresp", BRESP, 0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        step();
        check("postrst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        $display("RST mid-transaction done");
        run_read(mk(1, 32'h30, 32'h0, 4'h0, 0, 0, 2'b00, 32'h0BADC0DE));
        run_write(mk(0, 32'h34, 32'h76543210, 4'hF, 2, 1, 2'b00, 32'h0));
        run_read(mk(1, 32'h34, 32'h0, 4'h0, 0, 0, 2'b00, 32'h76543210));

        check("b_scoreboard_drained", b_q.size(), 0);
        check("r_scoreboard_drained", r_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
